// File: rtl/vtw_fail_pkg.sv
// Shared types and defaults for the virtual-tester fail-capture block.
package vtw_fail_pkg;

    localparam int unsigned PIN_W_DEF     = 8;
    localparam int unsigned VEC_W_DEF     = 32;
    localparam int unsigned CYC_W_DEF     = 32;
    localparam int unsigned CNT_W_DEF     = 32;
    localparam int unsigned DEPTH_DEF     = 16;
    localparam int unsigned PULSE_CYC_DEF = 4;

    typedef struct packed {
        logic [PIN_W_DEF-1:0] pin;
        logic [VEC_W_DEF-1:0] vector;
        logic [CYC_W_DEF-1:0] cycle;
        logic                 real_val;
        logic                 exp_val;
    } fail_rec_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StEnd,
        StDone
    } state_t;

endpackage

// File: rtl/vtw_fail_fifo.sv
// Synchronous fail-record FIFO; a push into a full FIFO succeeds when a pop happens in the same
// cycle. Empty FIFO never bypasses: a pushed record is visible the following cycle.
module vtw_fail_fifo
    import vtw_fail_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter type         rec_t = fail_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_push,
    input  logic i_pop,
    input  rec_t i_wdata,
    output logic o_full,
    output logic o_empty,
    output rec_t o_rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    rec_t          r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // On push-while-full-with-pop the write lands in the slot being vacated this edge.
    always_ff @(posedge clk) begin
        if (w_push && !i_clr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/vtw_fail_capture.sv
// Capture end for tester compare results: counts compares/fails, queues fail records and emits
// the end-of-pattern pass/fail/end pulses.
module vtw_fail_capture
    import vtw_fail_pkg::*;
#(
    parameter int unsigned PIN_W     = PIN_W_DEF,
    parameter int unsigned VEC_W     = VEC_W_DEF,
    parameter int unsigned CYC_W     = CYC_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned PULSE_CYC = PULSE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cmp_valid,
    input  logic             cmp_mask,
    input  logic [PIN_W-1:0] cmp_pin,
    input  logic [VEC_W-1:0] cmp_vector,
    input  logic [CYC_W-1:0] cmp_cycle,
    input  logic             cmp_real,
    input  logic             cmp_exp,
    input  logic             test_done,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [PIN_W-1:0] rd_pin,
    output logic [VEC_W-1:0] rd_vector,
    output logic [CYC_W-1:0] rd_cycle,
    output logic             rd_real,
    output logic             rd_exp,
    output logic [CNT_W-1:0] compare_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] lost_count,
    output logic             overflow,
    output logic             test_pass,
    output logic             test_fail,
    output logic             test_end
);

    // Same field layout as fail_rec_t, sized by this instance's parameters.
    typedef struct packed {
        logic [PIN_W-1:0] pin;
        logic [VEC_W-1:0] vector;
        logic [CYC_W-1:0] cycle;
        logic             real_val;
        logic             exp_val;
    } rec_t;

    localparam int unsigned TW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    state_t           r_state, w_state_next;
    logic [TW-1:0]    r_timer, w_timer_next;
    logic             r_pass, w_pass_next;
    logic             r_fail, w_fail_next;
    logic             r_end, w_end_next;
    logic [CNT_W-1:0] r_cmp_cnt, r_fail_cnt, r_lost_cnt;
    logic             r_overflow;
    logic             w_active, w_accept, w_fail, w_pop, w_drop, w_push, w_done, w_any_fail;
    logic             w_full, w_empty;
    rec_t             w_wrec, w_rrec;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_active   = (r_state == StIdle) || (r_state == StRun);
    assign w_accept   = cmp_valid & w_active;
    assign w_fail     = w_accept & ~cmp_mask & (cmp_real ^ cmp_exp);
    assign w_pop      = ~w_empty & rd_ready;
    assign w_drop     = w_fail & w_full & ~w_pop;
    assign w_push     = w_fail & ~w_drop;
    assign w_done     = test_done & w_active;
    // A fail arriving with test_done still decides the verdict.
    assign w_any_fail = (r_fail_cnt != '0) | w_fail;

    assign w_wrec = '{pin: cmp_pin, vector: cmp_vector, cycle: cmp_cycle,
                      real_val: cmp_real, exp_val: cmp_exp};

    vtw_fail_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wrec),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_rdata (w_rrec)
    );

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_pass_next  = r_pass;
        w_fail_next  = r_fail;
        w_end_next   = r_end;
        case (r_state)
            StIdle, StRun: begin
                if (w_done) begin
                    w_state_next = StEnd;
                    w_timer_next = TW'(PULSE_CYC - 1);
                    w_end_next   = 1'b1;
                    w_pass_next  = ~w_any_fail;
                    w_fail_next  = w_any_fail;
                end else if (cmp_valid) begin
                    w_state_next = StRun;
                end
            end
            StEnd: begin
                if (r_timer == '0) begin
                    w_state_next = StDone;
                    w_end_next   = 1'b0;
                    w_pass_next  = 1'b0;
                    w_fail_next  = 1'b0;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_timer <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_end   <= 1'b0;
        end else if (clr) begin
            r_state <= StIdle;
            r_timer <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_pass  <= w_pass_next;
            r_fail  <= w_fail_next;
            r_end   <= w_end_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_cnt  <= '0;
            r_fail_cnt <= '0;
            r_lost_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_cmp_cnt  <= '0;
            r_fail_cnt <= '0;
            r_lost_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_cmp_cnt  <= sat_inc(r_cmp_cnt);
            if (w_fail)   r_fail_cnt <= sat_inc(r_fail_cnt);
            if (w_drop) begin
                r_lost_cnt <= sat_inc(r_lost_cnt);
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_valid      = ~w_empty;
    assign rd_pin        = w_rrec.pin;
    assign rd_vector     = w_rrec.vector;
    assign rd_cycle      = w_rrec.cycle;
    assign rd_real       = w_rrec.real_val;
    assign rd_exp        = w_rrec.exp_val;
    assign compare_count = r_cmp_cnt;
    assign fail_count    = r_fail_cnt;
    assign lost_count    = r_lost_cnt;
    assign overflow      = r_overflow;
    assign test_pass     = r_pass;
    assign test_fail     = r_fail;
    assign test_end      = r_end;

endmodule

// File: tb/tb_vtw_fail_capture.sv
// Directed bench for vtw_fail_capture with hand-computed expectations.
module tb_vtw_fail_capture;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic        cmp_valid, cmp_mask, cmp_real, cmp_exp, test_done;
    logic [7:0]  cmp_pin;
    logic [31:0] cmp_vector, cmp_cycle;
    logic        rd_valid, rd_ready, rd_real, rd_exp;
    logic [7:0]  rd_pin;
    logic [31:0] rd_vector, rd_cycle;
    logic [31:0] compare_count, fail_count, lost_count;
    logic        overflow, test_pass, test_fail, test_end;

    int unsigned n_compared = 0;
    int unsigned n_mismatch = 0;
    logic        rv_seen;

    always #5 clk = ~clk;

    vtw_fail_capture dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .cmp_valid     (cmp_valid),
        .cmp_mask      (cmp_mask),
        .cmp_pin       (cmp_pin),
        .cmp_vector    (cmp_vector),
        .cmp_cycle     (cmp_cycle),
        .cmp_real      (cmp_real),
        .cmp_exp       (cmp_exp),
        .test_done     (test_done),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_pin        (rd_pin),
        .rd_vector     (rd_vector),
        .rd_cycle      (rd_cycle),
        .rd_real       (rd_real),
        .rd_exp        (rd_exp),
        .compare_count (compare_count),
        .fail_count    (fail_count),
        .lost_count    (lost_count),
        .overflow      (overflow),
        .test_pass     (test_pass),
        .test_fail     (test_fail),
        .test_end      (test_end)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_compared++;
        if (obs !== want) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmp(input logic m, input logic [7:0] pin, input logic [31:0] vec,
                             input logic [31:0] cyc, input logic r, input logic e);
        cmp_valid  = 1'b1;
        cmp_mask   = m;
        cmp_pin    = pin;
        cmp_vector = vec;
        cmp_cycle  = cyc;
        cmp_real   = r;
        cmp_exp    = e;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; cmp_valid = 1'b0; cmp_mask = 1'b0; cmp_real = 1'b0;
        cmp_exp = 1'b0; test_done = 1'b0; cmp_pin = '0; cmp_vector = '0; cmp_cycle = '0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_rd_valid", rd_valid, 0);
        check("rst_cmp_cnt", compare_count, 0);
        check("rst_fail_cnt", fail_count, 0);
        check("rst_pulses", {test_pass, test_fail, test_end, overflow}, 0);
        check("rst_rd_pin", rd_pin, 0);

        // 1: pass run
        rv_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_cmp(1'b0, 8'(i), 32'(i), 32'(i), (i % 2) == 1, (i % 2) == 1);
            step();
            rv_seen |= rd_valid;
        end
        cmp_valid = 1'b0;
        test_done = 1'b1;
        step();
        test_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t1_pulse", {test_pass, test_fail, test_end}, 3'b101);
            rv_seen |= rd_valid;
            step();
        end
        check("t1_pulse_off", {test_pass, test_fail, test_end}, 3'b000);
        check("t1_cmp_cnt", compare_count, 10);
        check("t1_fail_cnt", fail_count, 0);
        check("t1_rv_never", rv_seen, 0);
        do_clr();

        // 2: single fail held until read
        drive_cmp(1'b0, 8'd5, 32'd100, 32'd257, 1'b0, 1'b1);
        step();
        cmp_valid = 1'b0;
        check("t2_rd_valid", rd_valid, 1);
        check("t2_fields", {rd_pin, rd_vector, rd_cycle, rd_real, rd_exp},
              {8'd5, 32'd100, 32'd257, 1'b0, 1'b1});
        step();
        step();
        check("t2_held", {rd_valid, rd_pin, rd_vector}, {1'b1, 8'd5, 32'd100});
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("t2_popped", rd_valid, 0);
        test_done = 1'b1;
        step();
        test_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t2_pulse", {test_pass, test_fail, test_end}, 3'b011);
            step();
        end
        check("t2_pulse_off", {test_pass, test_fail, test_end}, 3'b000);
        do_clr();

        // 3: overflow
        for (int i = 0; i < 20; i++) begin
            drive_cmp(1'b0, 8'(i), 32'(1000 + i), 32'(2000 + i), 1'b1, 1'b0);
            step();
        end
        cmp_valid = 1'b0;
        check("t3_fail_cnt", fail_count, 20);
        check("t3_lost_cnt", lost_count, 4);
        check("t3_overflow", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            check("t3_rd_valid", rd_valid, 1);
            check("t3_rd_rec", {rd_pin, rd_vector, rd_cycle},
                  {8'(i), 32'(1000 + i), 32'(2000 + i)});
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        check("t3_drained", rd_valid, 0);
        check("t3_lost_keep", lost_count, 4);
        do_clr();

        // 4: full with simultaneous pop
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                drive_cmp(1'b0, 8'hAA, 32'd500, 32'd600, 1'b0, 1'b1);
                rd_ready = 1'b1;
            end else begin
                drive_cmp(1'b0, 8'(i), 32'(i), 32'(i), 1'b0, 1'b1);
            end
            step();
        end
        cmp_valid = 1'b0;
        rd_ready  = 1'b0;
        check("t4_lost_cnt", lost_count, 0);
        check("t4_overflow", overflow, 0);
        check("t4_fail_cnt", fail_count, 17);
        for (int i = 0; i < 16; i++) begin
            check("t4_rd_valid", rd_valid, 1);
            check("t4_rd_pin", rd_pin, (i < 15) ? 8'(i + 1) : 8'hAA);
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        check("t4_drained", rd_valid, 0);
        do_clr();

        // 5: masked mismatch with same-cycle done, then DONE ignores inputs
        drive_cmp(1'b1, 8'd3, 32'd7, 32'd8, 1'b1, 1'b0);
        test_done = 1'b1;
        step();
        cmp_valid = 1'b0;
        test_done = 1'b0;
        check("t5_cmp_cnt", compare_count, 1);
        check("t5_fail_cnt", fail_count, 0);
        check("t5_pulse", {test_pass, test_fail, test_end}, 3'b101);
        repeat (4) step();
        check("t5_pulse_off", {test_pass, test_fail, test_end}, 3'b000);
        drive_cmp(1'b0, 8'd9, 32'd9, 32'd9, 1'b1, 1'b0);
        test_done = 1'b1;
        step();
        step();
        cmp_valid = 1'b0;
        test_done = 1'b0;
        step();
        check("t5_done_cmp", compare_count, 1);
        check("t5_done_fail", fail_count, 0);
        check("t5_done_quiet", {rd_valid, test_pass, test_fail, test_end}, 4'b0000);
        do_clr();

        // 6a: async reset during pulse cycle 2
        drive_cmp(1'b0, 8'd1, 32'd1, 32'd1, 1'b1, 1'b0);
        test_done = 1'b1;
        step();
        cmp_valid = 1'b0;
        test_done = 1'b0;
        check("t6_pulse_c1", {test_fail, test_end}, 2'b11);
        step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_pulses", {test_pass, test_fail, test_end, overflow}, 0);
        check("t6_rst_rd_valid", rd_valid, 0);
        check("t6_rst_cnts", {compare_count, fail_count, lost_count}, 0);
        step();
        rst_n = 1'b1;

        // 6b: clr mid-pulse with 3 records queued
        for (int i = 0; i < 3; i++) begin
            drive_cmp(1'b0, 8'(i + 40), 32'(i), 32'(i), 1'b1, 1'b0);
            step();
        end
        cmp_valid = 1'b0;
        test_done = 1'b1;
        step();
        test_done = 1'b0;
        check("t6_queued", {rd_valid, rd_pin}, {1'b1, 8'd40});
        clr = 1'b1;
        #1;
        check("t6_clr_before_edge", {test_fail, test_end}, 2'b11);
        step();
        clr = 1'b0;
        check("t6_clr_rd_valid", rd_valid, 0);
        check("t6_clr_cnts", {compare_count, fail_count, lost_count}, 0);
        check("t6_clr_pulses", {test_pass, test_fail, test_end, overflow}, 0);
        check("t6_clr_rd_pin", rd_pin, 0);
        drive_cmp(1'b0, 8'd2, 32'd2, 32'd2, 1'b0, 1'b0);
        step();
        cmp_valid = 1'b0;
        check("t6_idle_accepts", compare_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
